// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the mul_share_arb multiplier-sharing block.
// Round-robin pick supports up to four requesters.
package mul_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_t;

  localparam int STAT_W = 16;

  // Returns a one-hot grant, searching upward from last+1 modulo n.
  function automatic logic [3:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] last,
                                         input int n);
    logic [3:0] grant;
    logic [1:0] idx;
    grant = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k <= n) begin
        idx = 2'((int'(last) + k) % n);
        if (grant == '0 && valid[idx]) grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mul_array_core.sv
// Combinational unsigned WIDTH x WIDTH array multiplier producing the full
// 2*WIDTH product as a sum of shifted partial products.
module mul_array_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] acc;

  assign a_ext = {{WIDTH{1'b0}}, a};

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) acc = acc + (a_ext << i);
    end
  end

  assign p = acc;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter/sequencer sharing one array multiplier among NREQ
// requesters. Define MUL_SHARE_STATS_EN to add per-requester grant counters.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*WIDTH-1:0]    res_prod,
  output logic [ID_W-1:0]       res_id,
  output logic                  busy
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [ID_W-1:0]    op_id;
  logic [2*WIDTH-1:0] mul_p;

  logic [3:0]         valid_pad;
  logic [3:0]         grant_pad;
  logic [NREQ-1:0]    grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;

  // A new operand pair can enter only when the product register is free or
  // is being drained this very cycle.
  always_comb begin
    valid_pad = 4'(req_valid);
    grant_pad = rr_pick(valid_pad, 2'(last_grant), NREQ);
    grant_oh  = grant_pad[NREQ-1:0];
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) grant_idx = ID_W'(i);
    end
    accept    = (|req_valid) &&
                ((state == ST_IDLE) || ((state == ST_HOLD) && res_ready));
    req_ready = accept ? grant_oh : '0;
  end

  mul_array_core #(
    .WIDTH(WIDTH)
  ) u_mul (
    .a(op_a),
    .b(op_b),
    .p(mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      res_valid  <= 1'b0;
      res_prod   <= '0;
      res_id     <= '0;
      busy       <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= req_a[grant_idx*WIDTH +: WIDTH];
        op_b       <= req_b[grant_idx*WIDTH +: WIDTH];
        op_id      <= grant_idx;
        last_grant <= grant_idx;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_MUL;
            busy  <= 1'b1;
          end
        end
        ST_MUL: begin
          res_prod  <= mul_p;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (accept) begin
              state <= ST_MUL;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_SHARE_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] grant_cnt;

  assign stat_grants = grant_cnt;

  // Counters saturate rather than wrap so a long run never reads as few grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (accept && (grant_cnt[grant_idx] != {STAT_W{1'b1}})) begin
      grant_cnt[grant_idx] <= grant_cnt[grant_idx] + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: requester queues drive operands, a
// negedge monitor pops expected {product,id} on every result handshake.
module tb_mul_share_arb;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_prod;
  logic        res_id;
  logic        busy;
`ifdef MUL_SHARE_STATS_EN
  logic [31:0] stat_grants;
`endif

  mul_share_arb #(
    .WIDTH(WIDTH),
    .NREQ (NREQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_prod (res_prod),
    .res_id   (res_id),
`ifdef MUL_SHARE_STATS_EN
    .stat_grants(stat_grants),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct packed {
    logic [15:0] prod;
    logic        id;
  } exp_t;

  op_t  rq0[$];
  op_t  rq1[$];
  exp_t sb[$];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_res_cyc = 0;
  int prev_res_cyc = 0;
  int r0_ready_cnt = 0;
  logic [1:0] hs_seen = 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] a, input logic [7:0] b);
    op_t op;
    op.a = a;
    op.b = b;
    if (req == 0) rq0.push_back(op);
    else rq1.push_back(op);
  endtask

  task automatic expectResult(input logic [15:0] prod, input logic id);
    exp_t e;
    e.prod = prod;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic sampleStep();
    @(negedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      sampleStep();
      done = (sb.size() == 0) && (rq0.size() == 0) && (rq1.size() == 0) && !busy;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    rq0.delete();
    rq1.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    sampleStep();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: hold valid and operands until a handshake, then advance.
  initial begin
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_seen[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (hs_seen[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid[0] = (rq0.size() > 0);
      req_valid[1] = (rq1.size() > 0);
      if (rq0.size() > 0) begin
        req_a[7:0] = rq0[0].a;
        req_b[7:0] = rq0[0].b;
      end
      if (rq1.size() > 0) begin
        req_a[15:8] = rq1[0].a;
        req_b[15:8] = rq1[0].b;
      end
    end
  end

  // Monitor: records handshakes and checks every emitted result.
  always @(negedge clk) begin
    exp_t e;
    hs_seen = req_valid & req_ready;
    if (!rst) begin
      checkOutput("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (req_ready != 2'b00) last_acc_cyc = cyc;
      if (req_ready[0]) r0_ready_cnt++;
      if (res_valid && res_ready) begin
        prev_res_cyc = last_res_cyc;
        last_res_cyc = cyc;
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("res_prod", 32'(res_prod), 32'(e.prod));
          checkOutput("res_id", 32'(res_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;

    // Reset values
    sampleStep();
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_prod", 32'(res_prod), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sampleStep();

    // Single request: 7*9
    r0_ready_cnt = 0;
    applyStimulus(0, 8'h07, 8'h09);
    expectResult(16'h003F, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      sampleStep();
      seen = (sb.size() == 0);
    end
    checkOutput("t1_result_seen", 32'(seen), 32'd1);
    checkOutput("t1_latency", 32'(last_res_cyc - last_acc_cyc), 32'd2);
    checkOutput("t1_busy_in_hold", 32'(busy), 32'd1);
    sampleStep();
    checkOutput("t1_busy_falls", 32'(busy), 32'd0);
    checkOutput("t1_res_valid_falls", 32'(res_valid), 32'd0);
    checkOutput("t1_r0_ready_cycles", 32'(r0_ready_cnt), 32'd1);

    // Contention after reset: r0 first, then r1 two cycles later
    doReset();
    applyStimulus(0, 8'h10, 8'h10);
    applyStimulus(1, 8'hFF, 8'hFF);
    expectResult(16'h0100, 1'b0);
    expectResult(16'hFE01, 1'b1);
    waitDrain("t2_drain", 30);
    checkOutput("t2_result_spacing", 32'(last_res_cyc - prev_res_cyc), 32'd2);

    // Backpressure in HOLD, then back-to-back accept of pending r1
    doReset();
    res_ready = 1'b0;
    applyStimulus(0, 8'h03, 8'h05);
    applyStimulus(1, 8'h0A, 8'h0B);
    expectResult(16'h000F, 1'b0);
    expectResult(16'h006E, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      sampleStep();
      seen = res_valid;
    end
    checkOutput("t3_hold_reached", 32'(seen), 32'd1);
    for (int n = 0; n < 5; n++) begin
      sampleStep();
      checkOutput("t3_hold_valid", 32'(res_valid), 32'd1);
      checkOutput("t3_hold_prod", 32'(res_prod), 32'h000F);
      checkOutput("t3_hold_id", 32'(res_id), 32'd0);
      checkOutput("t3_hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    sampleStep();
    checkOutput("t3_b2b_req_ready", 32'(req_ready), 32'b10);
    waitDrain("t3_drain", 30);
    checkOutput("t3_result_spacing", 32'(last_res_cyc - prev_res_cyc), 32'd2);

    // Fairness: both requesters valid for 8 results, ids alternate
    doReset();
    applyStimulus(0, 8'h01, 8'h02);
    applyStimulus(0, 8'h03, 8'h04);
    applyStimulus(0, 8'h05, 8'h06);
    applyStimulus(0, 8'h07, 8'h08);
    applyStimulus(1, 8'h00, 8'h55);
    applyStimulus(1, 8'hFF, 8'h01);
    applyStimulus(1, 8'h80, 8'h02);
    applyStimulus(1, 8'h0F, 8'h11);
    expectResult(16'h0002, 1'b0);
    expectResult(16'h0000, 1'b1);
    expectResult(16'h000C, 1'b0);
    expectResult(16'h00FF, 1'b1);
    expectResult(16'h001E, 1'b0);
    expectResult(16'h0100, 1'b1);
    expectResult(16'h0038, 1'b0);
    expectResult(16'h00FF, 1'b1);
    waitDrain("t4_drain", 60);

    // Async reset during MUL discards the transaction
    doReset();
    applyStimulus(0, 8'h12, 8'h34);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      sampleStep();
      seen = req_ready[0];
    end
    checkOutput("t5_accept_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("t5_busy_in_mul", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t5_async_busy", 32'(busy), 32'd0);
    rq0.delete();
    rq1.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) sampleStep();
    checkOutput("t5_no_result_busy", 32'(busy), 32'd0);
    applyStimulus(1, 8'h04, 8'h05);
    applyStimulus(0, 8'h02, 8'h03);
    expectResult(16'h0006, 1'b0);
    expectResult(16'h0014, 1'b1);
    waitDrain("t5_drain", 30);

    // Async reset during HOLD drops res_valid immediately
    doReset();
    res_ready = 1'b0;
    applyStimulus(1, 8'hFF, 8'hFF);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      sampleStep();
      seen = res_valid;
    end
    checkOutput("t5b_hold_reached", 32'(seen), 32'd1);
    checkOutput("t5b_hold_prod", 32'(res_prod), 32'hFE01);
    rst = 1'b1;
    #1;
    checkOutput("t5b_async_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t5b_async_res_prod", 32'(res_prod), 32'd0);
    checkOutput("t5b_async_res_id", 32'(res_id), 32'd0);
    res_ready = 1'b1;
    doReset();

`ifdef MUL_SHARE_STATS_EN
    // Grant counters: three for r0, one for r1
    checkOutput("t6_stats_cleared", stat_grants, 32'd0);
    applyStimulus(0, 8'h01, 8'h01);
    applyStimulus(0, 8'h02, 8'h02);
    applyStimulus(0, 8'h03, 8'h03);
    applyStimulus(1, 8'h04, 8'h04);
    expectResult(16'h0001, 1'b0);
    expectResult(16'h0010, 1'b1);
    expectResult(16'h0004, 1'b0);
    expectResult(16'h0009, 1'b0);
    waitDrain("t6_drain", 40);
    checkOutput("t6_stat_grants", stat_grants, {16'd1, 16'd3});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
